// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: load extraction, RF write pulse, instret, PC commit.
// One instruction in flight; accepts again only after IFU takes the commit.
module ysyx_25020037_wbu #(
  parameter int          XLEN         = 32,
  parameter int          RF_ADDR_W    = 5,
  parameter logic [31:0] PC_RESET     = 32'h8000_0000,
  parameter logic [63:0] INSTRET_INIT = 64'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid,
  output logic                 wbu_ready,
  input  logic [XLEN-1:0]      lu_to_wu_bus,
  input  logic [RF_ADDR_W-1:0] wu_rd,
  input  logic                 wu_rf_we,
  input  logic                 wu_is_load,
  input  logic [2:0]           wu_ld_funct3,
  input  logic [1:0]           wu_addr_lo,
  input  logic [XLEN-1:0]      wu_dnpc,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 wbu_valid,
  input  logic                 ifu_ready,
  output logic [XLEN-1:0]      commit_pc,
  output logic [63:0]          instret,
  output logic                 wb_err
);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t state_q, state_d;

  logic            accept;
  logic            done;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  logic            ld_err;
  logic [XLEN-1:0] wdata_d;

  assign accept = lsu_valid & wbu_ready;
  assign done   = wbu_valid & ifu_ready;

  assign ld_b = lu_to_wu_bus[{wu_addr_lo, 3'b000} +: 8];
  assign ld_h = lu_to_wu_bus[{wu_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = '0;
    ld_err = 1'b0;
    unique case (wu_ld_funct3)
      3'b000: ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_b};
      3'b001: begin
        ld_err = wu_addr_lo[0];
        ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
      end
      3'b101: begin
        ld_err = wu_addr_lo[0];
        ld_val = {{(XLEN-16){1'b0}}, ld_h};
      end
      3'b010: begin
        ld_err = |wu_addr_lo;
        ld_val = lu_to_wu_bus;
      end
      default: ld_err = 1'b1;
    endcase
    if (!wu_is_load)  wdata_d = lu_to_wu_bus;
    else if (ld_err)  wdata_d = '0;
    else              wdata_d = ld_val;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = COMMIT;
      COMMIT:  if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wbu_ready <= 1'b1;
      wbu_valid <= 1'b0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      commit_pc <= PC_RESET[XLEN-1:0];
      instret   <= INSTRET_INIT;
      wb_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_wen  <= 1'b0;
      if (accept) begin
        rf_wen    <= wu_rf_we & (wu_rd != '0);
        rf_waddr  <= wu_rd;
        rf_wdata  <= wdata_d;
        commit_pc <= wu_dnpc;
        wbu_valid <= 1'b1;
        wbu_ready <= 1'b0;
        instret   <= instret + 64'd1;
        if (wu_is_load & ld_err) wb_err <= 1'b1;
      end else if (done) begin
        wbu_valid <= 1'b0;
        wbu_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Directed bench for ysyx_25020037_wbu: vector table plus
// backpressure, counter-wrap and async-reset sequences.
module tb_ysyx_25020037_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        wbu_ready;
  logic [31:0] lu_to_wu_bus = '0;
  logic [4:0]  wu_rd = '0;
  logic        wu_rf_we = 1'b0;
  logic        wu_is_load = 1'b0;
  logic [2:0]  wu_ld_funct3 = '0;
  logic [1:0]  wu_addr_lo = '0;
  logic [31:0] wu_dnpc = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wbu_valid;
  logic        ifu_ready = 1'b1;
  logic [31:0] commit_pc;
  logic [63:0] instret;
  logic        wb_err;

  logic        w_ready, w_wen, w_valid, w_err;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata, w_pc;
  logic [63:0] w_instret;

  int checks = 0;
  int errors = 0;
  longint unsigned cnt = 0;

  always #5 clk = ~clk;

  ysyx_25020037_wbu dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .lu_to_wu_bus(lu_to_wu_bus), .wu_rd(wu_rd),
    .wu_rf_we(wu_rf_we), .wu_is_load(wu_is_load),
    .wu_ld_funct3(wu_ld_funct3), .wu_addr_lo(wu_addr_lo),
    .wu_dnpc(wu_dnpc), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wbu_valid(wbu_valid), .ifu_ready(ifu_ready),
    .commit_pc(commit_pc), .instret(instret),
    .wb_err(wb_err)
  );

  ysyx_25020037_wbu #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .wbu_ready(w_ready),
    .lu_to_wu_bus(lu_to_wu_bus), .wu_rd(wu_rd),
    .wu_rf_we(wu_rf_we), .wu_is_load(wu_is_load),
    .wu_ld_funct3(wu_ld_funct3), .wu_addr_lo(wu_addr_lo),
    .wu_dnpc(wu_dnpc), .rf_wen(w_wen),
    .rf_waddr(w_waddr), .rf_wdata(w_wdata),
    .wbu_valid(w_valid), .ifu_ready(ifu_ready),
    .commit_pc(w_pc), .instret(w_instret),
    .wb_err(w_err)
  );

  typedef struct {
    string       name;
    logic [31:0] bus;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] dnpc;
    logic [31:0] exp_wdata;
    logic        exp_wen;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    lu_to_wu_bus = v.bus;
    wu_rd        = v.rd;
    wu_rf_we     = v.we;
    wu_is_load   = v.ld;
    wu_ld_funct3 = v.f3;
    wu_addr_lo   = v.lo;
    wu_dnpc      = v.dnpc;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    lsu_valid = 1'b1;
    ifu_ready = 1'b1;
    @(posedge clk);
    #1 lsu_valid = 1'b0;
    cnt++;
    @(negedge clk);
    chk({v.name, " rf_wen"}, 64'(rf_wen), 64'(v.exp_wen));
    chk({v.name, " rf_waddr"}, 64'(rf_waddr), 64'(v.rd));
    chk({v.name, " rf_wdata"}, 64'(rf_wdata), 64'(v.exp_wdata));
    chk({v.name, " wbu_valid"}, 64'(wbu_valid), 64'd1);
    chk({v.name, " wbu_ready"}, 64'(wbu_ready), 64'd0);
    chk({v.name, " commit_pc"}, 64'(commit_pc), 64'(v.dnpc));
    chk({v.name, " instret"}, instret, cnt);
    chk({v.name, " wb_err"}, 64'(wb_err), 64'(v.exp_err));
    @(negedge clk);
    chk({v.name, " wen_drop"}, 64'(rf_wen), 64'd0);
    chk({v.name, " ready_back"}, 64'(wbu_ready), 64'd1);
    chk({v.name, " valid_drop"}, 64'(wbu_valid), 64'd0);
  endtask

  function automatic vec_t mk(string n, logic [31:0] b, logic [4:0] rd,
      logic we, logic ld, logic [2:0] f3, logic [1:0] lo,
      logic [31:0] pc, logic [31:0] wd, logic wen, logic err);
    vec_t v;
    v.name = n; v.bus = b; v.rd = rd; v.we = we; v.ld = ld;
    v.f3 = f3; v.lo = lo; v.dnpc = pc; v.exp_wdata = wd;
    v.exp_wen = wen; v.exp_err = err;
    return v;
  endfunction

  initial begin
    int pulses;
    logic [31:0] word;
    word = 32'h80FF_7F01;

    vecs.push_back(mk("x0", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0,
                      32'h8000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0));
    vecs.push_back(mk("alu", 32'h1234_5678, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0,
                      32'h8000_0004, 32'h1234_5678, 1'b1, 1'b0));
    vecs.push_back(mk("nowe", 32'h0000_00AA, 5'd7, 1'b0, 1'b0, 3'b000, 2'd0,
                      32'h8000_0008, 32'h0000_00AA, 1'b0, 1'b0));
    vecs.push_back(mk("lb3", word, 5'd1, 1'b1, 1'b1, 3'b000, 2'd3,
                      32'h8000_000C, 32'hFFFF_FF80, 1'b1, 1'b0));
    vecs.push_back(mk("lbu2", word, 5'd2, 1'b1, 1'b1, 3'b100, 2'd2,
                      32'h8000_0010, 32'h0000_00FF, 1'b1, 1'b0));
    vecs.push_back(mk("lh2", word, 5'd3, 1'b1, 1'b1, 3'b001, 2'd2,
                      32'h8000_0014, 32'hFFFF_80FF, 1'b1, 1'b0));
    vecs.push_back(mk("lhu0", word, 5'd4, 1'b1, 1'b1, 3'b101, 2'd0,
                      32'h8000_0018, 32'h0000_7F01, 1'b1, 1'b0));
    vecs.push_back(mk("lw0", word, 5'd31, 1'b1, 1'b1, 3'b010, 2'd0,
                      32'h8000_001C, 32'h80FF_7F01, 1'b1, 1'b0));
    vecs.push_back(mk("lb1", word, 5'd6, 1'b1, 1'b1, 3'b000, 2'd1,
                      32'h8000_0020, 32'h0000_007F, 1'b1, 1'b0));
    vecs.push_back(mk("lw2_mis", word, 5'd8, 1'b1, 1'b1, 3'b010, 2'd2,
                      32'h8000_0024, 32'h0000_0000, 1'b1, 1'b1));
    vecs.push_back(mk("good_after", 32'h0BAD_F00D, 5'd9, 1'b1, 1'b0, 3'b000,
                      2'd0, 32'h8000_0028, 32'h0BAD_F00D, 1'b1, 1'b1));
    vecs.push_back(mk("lh1_mis", word, 5'd10, 1'b1, 1'b1, 3'b001, 2'd1,
                      32'h8000_002C, 32'h0000_0000, 1'b1, 1'b1));
    vecs.push_back(mk("f3_011", word, 5'd11, 1'b1, 1'b1, 3'b011, 2'd0,
                      32'h8000_0030, 32'h0000_0000, 1'b1, 1'b1));
    vecs.push_back(mk("lhu2", word, 5'd12, 1'b1, 1'b1, 3'b101, 2'd2,
                      32'h8000_0034, 32'h0000_80FF, 1'b1, 1'b1));

    #12;
    chk("rst wbu_ready", 64'(wbu_ready), 64'd1);
    chk("rst wbu_valid", 64'(wbu_valid), 64'd0);
    chk("rst rf_wen", 64'(rf_wen), 64'd0);
    chk("rst rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst commit_pc", 64'(commit_pc), 64'h8000_0000);
    chk("rst instret", instret, 64'd0);
    chk("rst wb_err", 64'(wb_err), 64'd0);
    chk("rst wrap instret", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("wrap instret", w_instret, 64'd0);
    end

    // Backpressure: IFU stalls 5 cycles while LSU keeps offering.
    drive(mk("bp", 32'hCAFE_0001, 5'd13, 1'b1, 1'b0, 3'b000, 2'd0,
             32'h8000_0200, 32'h0, 1'b0, 1'b0));
    lsu_valid = 1'b1;
    ifu_ready = 1'b0;
    pulses = 0;
    @(posedge clk);
    cnt++;
    #1 lu_to_wu_bus = 32'h5555_AAAA;
    wu_dnpc = 32'h9000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rf_wen) pulses++;
      chk("bp wbu_ready", 64'(wbu_ready), 64'd0);
      chk("bp wbu_valid", 64'(wbu_valid), 64'd1);
      chk("bp commit_pc", 64'(commit_pc), 64'h8000_0200);
    end
    lsu_valid = 1'b0;
    ifu_ready = 1'b1;
    @(negedge clk);
    chk("bp pulses", 64'(pulses), 64'd1);
    chk("bp rf_wdata", 64'(rf_wdata), 64'hCAFE_0001);
    chk("bp instret", instret, cnt);
    chk("bp ready_back", 64'(wbu_ready), 64'd1);
    chk("bp valid_drop", 64'(wbu_valid), 64'd0);
    chk("bp err sticky", 64'(wb_err), 64'd1);

    // Async reset in the middle of a commit.
    drive(mk("ar", 32'h7777_7777, 5'd14, 1'b1, 1'b0, 3'b000, 2'd0,
             32'h8000_0300, 32'h0, 1'b0, 1'b0));
    lsu_valid = 1'b1;
    ifu_ready = 1'b0;
    @(posedge clk);
    #1 lsu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar wbu_valid", 64'(wbu_valid), 64'd0);
    chk("ar wbu_ready", 64'(wbu_ready), 64'd1);
    chk("ar commit_pc", 64'(commit_pc), 64'h8000_0000);
    chk("ar rf_wen", 64'(rf_wen), 64'd0);
    chk("ar instret", instret, 64'd0);
    chk("ar wb_err", 64'(wb_err), 64'd0);
    ifu_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rf_wen) pulses++;
    end
    chk("ar no wen", 64'(pulses), 64'd0);
    chk("ar idle ready", 64'(wbu_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
